// File: rtl/sim_ctrl_seq.sv
// Cycle-level simulation sequencer: owns the SimTop reset window, host init/step
// handshakes, cycle limit, log window, perf pulses and a buffered UART drain path.
module sim_ctrl_seq #(
    parameter int RESET_CYCLES = 50,
    parameter int UART_DEPTH   = 16
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [63:0] cfg_max_cycles,
    input  logic [63:0] cfg_log_begin,
    input  logic [63:0] cfg_log_end,
    input  logic [31:0] cfg_perf_interval,
    output logic        dut_reset,
    output logic        dut_clk_en,
    output logic        init_req,
    input  logic        init_ack,
    output logic        step_req,
    input  logic        step_ack,
    input  logic        step_stop,
    output logic        log_enable,
    output logic        perf_clean,
    output logic        perf_dump,
    input  logic        uart_in_valid,
    input  logic [7:0]  uart_in_ch,
    output logic        uart_out_valid,
    input  logic        uart_out_ready,
    output logic [7:0]  uart_out_ch,
    output logic [15:0] uart_drop_cnt,
    output logic [63:0] cycle_cnt,
    output logic        finish,
    output logic [1:0]  finish_cause
);

    localparam int AW = $clog2(UART_DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    typedef enum logic [2:0] {HOLD, INIT, RUN, STEP, DONE} state_e;

    state_e      state_q, state_d;
    logic [31:0] hold_q, hold_d;
    logic [63:0] cycle_q, cycle_d;
    logic [31:0] perf_q, perf_d;
    logic [1:0]  cause_q, cause_d;
    logic        ran_q, ran_d;
    logic        done_dump_q, done_dump_d;

    logic [AW:0] wr_q, rd_q;
    logic [7:0]  mem_q [UART_DEPTH];
    logic [15:0] drop_q;
    logic        fifo_empty, fifo_full, push_req, push, pop, drop;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= HOLD;
            hold_q      <= '0;
            cycle_q     <= '0;
            perf_q      <= '0;
            cause_q     <= '0;
            ran_q       <= 1'b0;
            done_dump_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            hold_q      <= hold_d;
            cycle_q     <= cycle_d;
            perf_q      <= perf_d;
            cause_q     <= cause_d;
            ran_q       <= ran_d;
            done_dump_q <= done_dump_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        hold_d      = hold_q;
        cycle_d     = cycle_q;
        perf_d      = perf_q;
        cause_d     = cause_q;
        ran_d       = ran_q;
        done_dump_d = done_dump_q;
        dut_reset   = 1'b0;
        dut_clk_en  = 1'b0;
        init_req    = 1'b0;
        step_req    = 1'b0;
        perf_clean  = 1'b0;
        perf_dump   = 1'b0;
        case (state_q)
            HOLD: begin
                dut_reset = 1'b1;
                if (hold_q == 32'(RESET_CYCLES - 1)) state_d = INIT;
                else hold_d = hold_q + 32'd1;
            end
            INIT: begin
                init_req = 1'b1;
                if (init_ack) begin
                    state_d = RUN;
                    perf_d  = cfg_perf_interval;
                end
            end
            RUN: begin
                dut_clk_en = 1'b1;
                perf_clean = !ran_q;
                ran_d      = 1'b1;
                cycle_d    = cycle_q + 64'd1;
                state_d    = STEP;
                // An interval of 0 leaves the counter parked at 0 so no periodic dump fires.
                if (perf_q == 32'd1) begin
                    perf_dump = 1'b1;
                    perf_d    = cfg_perf_interval;
                end else if (perf_q != 32'd0) begin
                    perf_d = perf_q - 32'd1;
                end
            end
            STEP: begin
                step_req = 1'b1;
                if (step_ack) begin
                    if (step_stop) begin
                        state_d = DONE;
                        cause_d = 2'd1;
                    end else if (cfg_max_cycles != 64'd0 && cycle_q >= cfg_max_cycles) begin
                        state_d = DONE;
                        cause_d = 2'd2;
                    end else begin
                        state_d = RUN;
                    end
                end
            end
            DONE: begin
                perf_dump   = !done_dump_q;
                done_dump_d = 1'b1;
            end
            default: state_d = HOLD;
        endcase
    end

    assign log_enable   = (state_q == RUN || state_q == STEP) &&
                          (cycle_q >= cfg_log_begin) && (cycle_q <= cfg_log_end);
    assign cycle_cnt    = cycle_q;
    assign finish_cause = cause_q;
    assign finish       = (state_q == DONE) && fifo_empty;

    // A full FIFO still takes a character when the head leaves in the same cycle.
    assign fifo_empty     = (wr_q == rd_q);
    assign fifo_full      = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign push_req       = dut_clk_en && uart_in_valid;
    assign pop            = !fifo_empty && uart_out_ready;
    assign push           = push_req && (!fifo_full || pop);
    assign drop           = push_req && fifo_full && !pop;
    assign uart_out_valid = !fifo_empty;
    assign uart_out_ch    = mem_q[rd_q[AW-1:0]];
    assign uart_drop_cnt  = drop_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_q   <= '0;
            rd_q   <= '0;
            drop_q <= '0;
        end else begin
            if (push) wr_q <= wr_q + PTR_ONE;
            if (pop) rd_q <= rd_q + PTR_ONE;
            if (drop && drop_q != 16'hFFFF) drop_q <= drop_q + 16'd1;
        end
    end

    always_ff @(posedge clock) begin
        if (push) mem_q[wr_q[AW-1:0]] <= uart_in_ch;
    end

endmodule

// File: tb/tb_sim_ctrl_seq.sv
// Bench for sim_ctrl_seq: a reference model of the sequencer rules is checked against
// the DUT every cycle, plus directed scenarios with hand-computed expectations.
module tb_sim_ctrl_seq;

    localparam int RC    = 4;
    localparam int DEPTH = 4;

    logic        clock = 1'b0;
    logic        reset;
    logic [63:0] cfg_max_cycles, cfg_log_begin, cfg_log_end;
    logic [31:0] cfg_perf_interval;
    logic        dut_reset, dut_clk_en, init_req, init_ack, step_req, step_ack, step_stop;
    logic        log_enable, perf_clean, perf_dump;
    logic        uart_in_valid, uart_out_valid, uart_out_ready;
    logic [7:0]  uart_in_ch, uart_out_ch;
    logic [15:0] uart_drop_cnt;
    logic [63:0] cycle_cnt;
    logic        finish;
    logic [1:0]  finish_cause;

    int total = 0;
    int bad   = 0;

    sim_ctrl_seq #(.RESET_CYCLES(RC), .UART_DEPTH(DEPTH)) dut (
        .clock(clock), .reset(reset),
        .cfg_max_cycles(cfg_max_cycles), .cfg_log_begin(cfg_log_begin),
        .cfg_log_end(cfg_log_end), .cfg_perf_interval(cfg_perf_interval),
        .dut_reset(dut_reset), .dut_clk_en(dut_clk_en),
        .init_req(init_req), .init_ack(init_ack),
        .step_req(step_req), .step_ack(step_ack), .step_stop(step_stop),
        .log_enable(log_enable), .perf_clean(perf_clean), .perf_dump(perf_dump),
        .uart_in_valid(uart_in_valid), .uart_in_ch(uart_in_ch),
        .uart_out_valid(uart_out_valid), .uart_out_ready(uart_out_ready),
        .uart_out_ch(uart_out_ch), .uart_drop_cnt(uart_drop_cnt),
        .cycle_cnt(cycle_cnt), .finish(finish), .finish_cause(finish_cause)
    );

    always #5 clock = ~clock;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("[TB] FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, req, $time);
        end
    endtask

    // Reference model: progress expressed as "reset window elapsed", "init granted",
    // "a DUT cycle is owed a host check" and "finished", plus a queue for the UART.
    int              sinceRel = 0;
    bit              initGranted = 0, stepOwed = 0, mDone = 0;
    longint unsigned mCycles = 0;
    int              doneAge = 0;
    logic [1:0]      mCause = 0;
    int              mDrops = 0;
    logic [7:0]      mq[$];
    bit              mFull, mPop, mPush;

    function automatic bit mClkEn();
        return initGranted && !stepOwed && !mDone;
    endfunction
    function automatic bit mStepReq();
        return stepOwed && !mDone;
    endfunction
    function automatic bit mPerfDump();
        if (mDone) return doneAge == 0;
        if (mClkEn() && cfg_perf_interval != 32'd0)
            return ((mCycles + 64'd1) % {32'd0, cfg_perf_interval}) == 64'd0;
        return 1'b0;
    endfunction

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            sinceRel = 0; initGranted = 0; stepOwed = 0; mDone = 0; mCycles = 0;
            doneAge = 0; mCause = 0; mDrops = 0; mq.delete();
        end else begin
            mFull = (mq.size() == DEPTH);
            mPop  = (mq.size() > 0) && uart_out_ready;
            mPush = mClkEn() && uart_in_valid;
            if (mPop) void'(mq.pop_front());
            if (mPush) begin
                if (!mFull || mPop) mq.push_back(uart_in_ch);
                else if (mDrops < 65535) mDrops++;
            end
            if (mDone) doneAge++;
            else if (sinceRel < RC) sinceRel++;
            else if (!initGranted) begin
                if (init_ack) initGranted = 1;
            end else if (!stepOwed) begin
                mCycles++;
                stepOwed = 1;
            end else if (step_ack) begin
                stepOwed = 0;
                if (step_stop) begin
                    mDone = 1; mCause = 2'd1; doneAge = 0;
                end else if (cfg_max_cycles != 64'd0 && mCycles >= cfg_max_cycles) begin
                    mDone = 1; mCause = 2'd2; doneAge = 0;
                end
            end
        end
    end

    // Per-cycle comparison of every output against the model.
    always @(negedge clock) begin
        checkOutput("dut_reset", 64'(dut_reset), 64'(sinceRel < RC));
        checkOutput("init_req", 64'(init_req), 64'(sinceRel >= RC && !initGranted));
        checkOutput("dut_clk_en", 64'(dut_clk_en), 64'(mClkEn()));
        checkOutput("step_req", 64'(step_req), 64'(mStepReq()));
        checkOutput("log_enable", 64'(log_enable), 64'((mClkEn() || mStepReq()) &&
                    mCycles >= cfg_log_begin && mCycles <= cfg_log_end));
        checkOutput("perf_clean", 64'(perf_clean), 64'(mClkEn() && mCycles == 0));
        checkOutput("perf_dump", 64'(perf_dump), 64'(mPerfDump()));
        checkOutput("cycle_cnt", cycle_cnt, mCycles);
        checkOutput("finish", 64'(finish), 64'(mDone && mq.size() == 0));
        checkOutput("finish_cause", 64'(finish_cause), 64'(mCause));
        checkOutput("uart_out_valid", 64'(uart_out_valid), 64'(mq.size() > 0));
        checkOutput("uart_drop_cnt", 64'(uart_drop_cnt), 64'(mDrops));
        if (mq.size() > 0) checkOutput("uart_out_ch", 64'(uart_out_ch), 64'(mq[0]));
    end

    // Event recorders used by the directed scenarios.
    int         clkEnCount, cleanCount, doneDumps, logCycles;
    logic [63:0] perfRuns[$];
    logic [7:0]  popped[$];
    always @(negedge clock) begin
        if (dut_clk_en) clkEnCount++;
        if (perf_clean) cleanCount++;
        if (perf_dump && dut_clk_en) perfRuns.push_back(cycle_cnt + 64'd1);
        if (perf_dump && !dut_clk_en) doneDumps++;
        if (log_enable) logCycles++;
        if (uart_out_valid && uart_out_ready) popped.push_back(uart_out_ch);
    end

    // Host step responder: acks every step immediately, stopping on a chosen step.
    int stopOnStep = 0;
    int stepsAcked = 0;
    initial begin
        step_ack = 0; step_stop = 0;
        forever begin
            @(posedge clock); #1;
            if (step_req && !reset) begin
                stepsAcked++;
                step_ack  = 1;
                step_stop = (stepsAcked == stopOnStep);
            end else begin
                step_ack = 0; step_stop = 0;
            end
        end
    end

    // DUT UART source: one queued char per DUT cycle; optional junk outside RUN.
    logic [7:0] feedQ[$];
    bit         feedJunk = 0;
    initial begin
        uart_in_valid = 0; uart_in_ch = 8'h00;
        forever begin
            @(posedge clock); #1;
            if (dut_clk_en && feedQ.size() > 0) begin
                uart_in_valid = 1; uart_in_ch = feedQ.pop_front();
            end else if (feedJunk && !dut_clk_en) begin
                uart_in_valid = 1; uart_in_ch = 8'h7E;
            end else begin
                uart_in_valid = 0;
            end
        end
    end

    task automatic tick();
        @(posedge clock); #1;
    endtask

    task automatic applyStimulus(input logic [63:0] maxc, input logic [31:0] perf,
                                 input logic [63:0] lb, input logic [63:0] le);
        reset = 1; init_ack = 0; uart_out_ready = 0;
        cfg_max_cycles = maxc; cfg_perf_interval = perf; cfg_log_begin = lb; cfg_log_end = le;
        feedQ.delete(); feedJunk = 0; stopOnStep = 0; stepsAcked = 0;
        repeat (2) tick();
        clkEnCount = 0; cleanCount = 0; doneDumps = 0; logCycles = 0;
        perfRuns.delete(); popped.delete();
        reset = 0;
    endtask

    task automatic doInit(input int late, output int latency);
        latency = 0;
        while (!init_req && latency < RC + 10) begin
            tick();
            latency++;
        end
        checkOutput("init_req_seen", 64'(init_req), 64'd1);
        for (int i = 0; i < late; i++) begin
            tick();
            checkOutput("init_req_held", 64'(init_req), 64'd1);
        end
        init_ack = 1;
        tick();
        init_ack = 0;
    endtask

    task automatic waitDone(input int budget);
        int n = 0;
        while (finish_cause == 2'd0 && n < budget) begin
            tick();
            n++;
        end
        checkOutput("done_reached", 64'(finish_cause != 2'd0), 64'd1);
    endtask

    initial begin
        int         lat;
        int         n;
        int         early;
        logic [7:0] expDrain[5];
        logic [7:0] expE[3];
        expDrain = '{8'h41, 8'h42, 8'h43, 8'h44, 8'h47};
        expE     = '{8'h61, 8'h62, 8'h63};

        // Reset/init timing, perf interval 4, log window 2..5, limit 13.
        applyStimulus(64'd13, 32'd4, 64'd2, 64'd5);
        checkOutput("reset_dut_reset", 64'(dut_reset), 64'd1);
        checkOutput("reset_cycle_cnt", cycle_cnt, 64'd0);
        doInit(3, lat);
        checkOutput("init_latency", 64'(lat), 64'(RC));
        checkOutput("first_clk_en", 64'(dut_clk_en), 64'd1);
        checkOutput("first_perf_clean", 64'(perf_clean), 64'd1);
        waitDone(200);
        repeat (3) tick();
        checkOutput("A_clk_en_pulses", 64'(clkEnCount), 64'd13);
        checkOutput("A_clean_pulses", 64'(cleanCount), 64'd1);
        checkOutput("A_perf_runs_n", 64'(perfRuns.size()), 64'd3);
        for (int i = 0; i < 3; i++)
            checkOutput($sformatf("A_perf_run%0d", i),
                        (i < perfRuns.size()) ? perfRuns[i] : 64'hDEAD, 64'(4 * (i + 1)));
        checkOutput("A_done_dumps", 64'(doneDumps), 64'd1);
        checkOutput("A_log_cycles", 64'(logCycles), 64'd8);
        checkOutput("A_cause", 64'(finish_cause), 64'd2);

        // Max cycles = 10, perf disabled, empty log window.
        applyStimulus(64'd10, 32'd0, 64'd1, 64'd0);
        doInit(0, lat);
        waitDone(200);
        repeat (3) tick();
        checkOutput("B_clk_en_pulses", 64'(clkEnCount), 64'd10);
        checkOutput("B_cycle_cnt", cycle_cnt, 64'd10);
        checkOutput("B_finish", 64'(finish), 64'd1);
        checkOutput("B_cause", 64'(finish_cause), 64'd2);
        checkOutput("B_done_dumps", 64'(doneDumps), 64'd1);
        checkOutput("B_perf_runs", 64'(perfRuns.size()), 64'd0);
        checkOutput("B_log_cycles", 64'(logCycles), 64'd0);

        // Host stop on the 3rd step.
        applyStimulus(64'd0, 32'd0, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF);
        stopOnStep = 3;
        doInit(0, lat);
        waitDone(200);
        repeat (10) tick();
        checkOutput("C_cycle_cnt", cycle_cnt, 64'd3);
        checkOutput("C_cause", 64'(finish_cause), 64'd1);
        checkOutput("C_clk_en_pulses", 64'(clkEnCount), 64'd3);
        checkOutput("C_done_dumps", 64'(doneDumps), 64'd1);

        // UART overflow with junk outside RUN, then full push+pop, then drain.
        applyStimulus(64'd0, 32'd0, 64'd0, 64'd0);
        feedJunk = 1;
        for (int c = 8'h41; c <= 8'h46; c++) feedQ.push_back(8'(c));
        doInit(0, lat);
        n = 0;
        while (feedQ.size() > 0 && n < 100) begin tick(); n++; end
        repeat (2) tick();
        checkOutput("D_drop_cnt", 64'(uart_drop_cnt), 64'd2);
        checkOutput("D_head", 64'(uart_out_ch), 64'h41);
        n = 0;
        while (!step_req && n < 10) begin tick(); n++; end
        feedQ.push_back(8'h47);
        tick();
        checkOutput("D_run_for_pushpop", 64'(dut_clk_en), 64'd1);
        uart_out_ready = 1;
        tick();
        uart_out_ready = 0;
        tick();
        checkOutput("D_drop_after_pushpop", 64'(uart_drop_cnt), 64'd2);
        uart_out_ready = 1;
        repeat (8) tick();
        checkOutput("D_drain_n", 64'(popped.size()), 64'd5);
        for (int i = 0; i < 5; i++)
            checkOutput($sformatf("D_drain%0d", i),
                        (i < popped.size()) ? 64'(popped[i]) : 64'hDEAD, 64'(expDrain[i]));
        feedJunk = 0;
        stopOnStep = stepsAcked + 2;
        waitDone(50);

        // Drain before finish, with toggling ready.
        applyStimulus(64'd0, 32'd0, 64'd0, 64'd0);
        stopOnStep = 3;
        feedQ.push_back(8'h61); feedQ.push_back(8'h62); feedQ.push_back(8'h63);
        doInit(0, lat);
        waitDone(100);
        checkOutput("E_finish_at_done", 64'(finish), 64'd0);
        n = 0; early = 0;
        while (!finish && n < 30) begin
            uart_out_ready = ~uart_out_ready;
            tick();
            n++;
            if (finish && popped.size() < 3) early++;
        end
        checkOutput("E_finish_rose", 64'(finish), 64'd1);
        checkOutput("E_finish_early", 64'(early), 64'd0);
        checkOutput("E_pops", 64'(popped.size()), 64'd3);
        for (int i = 0; i < 3; i++)
            checkOutput($sformatf("E_pop%0d", i),
                        (i < popped.size()) ? 64'(popped[i]) : 64'hDEAD, 64'(expE[i]));

        // Asynchronous reset in the middle of a RUN cycle.
        applyStimulus(64'd0, 32'd0, 64'd0, 64'd0);
        feedQ.push_back(8'h70);
        doInit(0, lat);
        n = 0;
        while (!(dut_clk_en && cycle_cnt >= 64'd3) && n < 50) begin tick(); n++; end
        checkOutput("F_pre_cycle_cnt", cycle_cnt, 64'd3);
        checkOutput("F_pre_uart_valid", 64'(uart_out_valid), 64'd1);
        #2;
        reset = 1;
        #1;
        checkOutput("F_cycle_cnt_cleared", cycle_cnt, 64'd0);
        checkOutput("F_fifo_flushed", 64'(uart_out_valid), 64'd0);
        checkOutput("F_dut_reset", 64'(dut_reset), 64'd1);
        checkOutput("F_clk_en_off", 64'(dut_clk_en), 64'd0);
        tick();
        reset = 0;
        repeat (3) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired actual=running required=finished");
        $fatal(1, "[TB] watchdog");
    end

endmodule
